// File: rtl/sokoban_pkg.sv
// Shared definitions for the Sokoban board renderer.
// Holds the tile codes stored in map RAM (and passed through as sprite ids),
// the screen limits, the default board geometry, and the render FSM types.
package sokoban_pkg;

  localparam logic [2:0] TILE_FLOOR         = 3'd0;
  localparam logic [2:0] TILE_WALL          = 3'd1;
  localparam logic [2:0] TILE_BOX           = 3'd2;
  localparam logic [2:0] TILE_GOAL          = 3'd3;
  localparam logic [2:0] TILE_BOX_ON_GOAL   = 3'd4;
  localparam logic [2:0] TILE_PLAYER        = 3'd5;
  localparam logic [2:0] TILE_PLAYER_ON_GOAL = 3'd6;
  localparam logic [2:0] TILE_BLANK         = 3'd7;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int DEF_GRID_W   = 16;
  localparam int DEF_GRID_H   = 12;
  localparam int DEF_TILE_PX  = 8;
  localparam int DEF_ORIGIN_X = 16;
  localparam int DEF_ORIGIN_Y = 12;
  localparam int DEF_QDEPTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_ADVANCE
  } render_state_t;

  typedef enum logic {
    MODE_SINGLE,
    MODE_FULL
  } render_mode_t;

  // Row-major map RAM address of tile (tx, ty).
  function automatic logic [7:0] tile_addr(input logic [3:0] tx,
                                           input logic [3:0] ty,
                                           input logic [7:0] grid_w);
    return ({4'b0, ty} * grid_w) + {4'b0, tx};
  endfunction

endpackage

// File: rtl/tile_req_fifo.sv
// Single-tile redraw request queue.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   push, din     enqueue din (ignored when full)
//   pop, dout     dequeue; dout is the current head (valid when !empty)
//   flush         empty the queue; a push in the same cycle is kept
//   full, empty   occupancy flags
module tile_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? ptr_next('0) : '0;
      count  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[flush ? '0 : wr_ptr] <= din;
  end

endmodule

// File: rtl/board_render_seq.sv
// Board render sequencer: walks the level map and issues one sprite_draw
// per tile, either a full-board scan or queued single-tile redraws.
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   full_req                 pulse: redraw the entire board
//   tile_req, tile_x/y_in    pulse: redraw one tile (accepted when tile_ready)
//   tile_ready               request queue not full
//   map_addr, map_data       map RAM read port (data one cycle after address)
//   x_out, y_out, sprite_id_out, draw_start, draw_done   sprite_draw handshake
//   busy                     sequencer not idle
//   frame_done               pulse at the end of a full redraw
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | wait for a pending full redraw or a queued tile request
// FETCH      | map_addr presented to map RAM
// READ       | map_data valid; latch sprite id and pixel coordinates
// ISSUE      | draw_start high for one cycle
// WAIT_DONE  | wait for draw_done from sprite_draw
// ADVANCE    | step to next tile, finish the frame, or return to IDLE
module board_render_seq
  import sokoban_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int TILE_PX  = DEF_TILE_PX,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int QDEPTH   = DEF_QDEPTH
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       full_req,
  input  logic       tile_req,
  input  logic [3:0] tile_x_in,
  input  logic [3:0] tile_y_in,
  output logic       tile_ready,
  output logic [7:0] map_addr,
  input  logic [2:0] map_data,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] sprite_id_out,
  output logic       draw_start,
  input  logic       draw_done,
  output logic       busy,
  output logic       frame_done
);

  localparam int         SHIFT   = $clog2(TILE_PX);
  localparam logic [3:0] TX_LAST = 4'(GRID_W - 1);
  localparam logic [3:0] TY_LAST = 4'(GRID_H - 1);
  localparam logic [4:0] GW5     = 5'(GRID_W);
  localparam logic [4:0] GH5     = 5'(GRID_H);
  localparam logic [7:0] GW8     = 8'(GRID_W);

  render_state_t state;
  render_mode_t  mode;
  logic [3:0]    tx, ty;
  logic          full_pending;
  logic          last_tile;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;

  assign last_tile  = (tx == TX_LAST) && (ty == TY_LAST);
  // Out-of-range coordinates never enter the queue.
  assign fifo_push  = tile_req && ({1'b0, tile_x_in} < GW5) && ({1'b0, tile_y_in} < GH5);
  assign fifo_pop   = (state == ST_IDLE) && !full_pending && !fifo_empty;
  // A full scan repaints every tile, so queued singles become redundant.
  assign fifo_flush = full_pending &&
                      ((state == ST_IDLE) ||
                       (state == ST_ADVANCE && mode == MODE_FULL && last_tile));
  assign tile_ready = !fifo_full;
  assign busy       = (state != ST_IDLE);

  tile_req_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (fifo_flush),
    .din    ({tile_y_in, tile_x_in}),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      mode          <= MODE_SINGLE;
      tx            <= '0;
      ty            <= '0;
      full_pending  <= 1'b0;
      map_addr      <= '0;
      x_out         <= '0;
      y_out         <= '0;
      sprite_id_out <= TILE_FLOOR;
      draw_start    <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      draw_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (full_pending) begin
            full_pending <= 1'b0;
            mode         <= MODE_FULL;
            tx           <= '0;
            ty           <= '0;
            map_addr     <= '0;
            state        <= ST_FETCH;
          end else if (!fifo_empty) begin
            mode     <= MODE_SINGLE;
            tx       <= fifo_dout[3:0];
            ty       <= fifo_dout[7:4];
            map_addr <= tile_addr(fifo_dout[3:0], fifo_dout[7:4], GW8);
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_READ;
        ST_READ: begin
          sprite_id_out <= map_data;
          x_out         <= 8'(ORIGIN_X) + ({4'b0, tx} << SHIFT);
          y_out         <= 7'(ORIGIN_Y) + ({3'b0, ty} << SHIFT);
          draw_start    <= 1'b1;
          state         <= ST_ISSUE;
        end
        ST_ISSUE: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (draw_done) state <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (mode == MODE_SINGLE) begin
            state <= ST_IDLE;
          end else if (last_tile) begin
            frame_done <= 1'b1;
            if (full_pending) begin
              full_pending <= 1'b0;
              tx           <= '0;
              ty           <= '0;
              map_addr     <= '0;
              state        <= ST_FETCH;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            if (tx == TX_LAST) begin
              tx <= '0;
              ty <= ty + 1'b1;
            end else begin
              tx <= tx + 1'b1;
            end
            // Row-major scan: the next tile is always the next address.
            map_addr <= map_addr + 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Placed last so a request arriving while one is being consumed survives.
      if (full_req) full_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_board_render_seq.sv
// Self-checking bench for board_render_seq: map RAM model, sprite_draw
// responder, and a reference model of the expected draw sequence.
module tb_board_render_seq;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       full_req = 1'b0;
  logic       tile_req = 1'b0;
  logic [3:0] tile_x_in = '0;
  logic [3:0] tile_y_in = '0;
  logic       tile_ready;
  logic [7:0] map_addr;
  logic [2:0] map_data = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] sprite_id_out;
  logic       draw_start;
  logic       draw_done = 1'b0;
  logic       busy;
  logic       frame_done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2:0] map_mem [256];

  logic [7:0] obs_x [$];
  logic [6:0] obs_y [$];
  logic [2:0] obs_id [$];
  int start_cnt = 0;
  int frame_cnt = 0;
  int stab_err = 0;

  bit resp_en = 1'b0;
  int resp_delay = 10;
  int inject_req = 0;
  int inject_ack = 0;
  logic [7:0] rs_x;
  logic [6:0] rs_y;
  logic [2:0] rs_id;

  board_render_seq dut (
    .clk           (clk),
    .resetn        (resetn),
    .full_req      (full_req),
    .tile_req      (tile_req),
    .tile_x_in     (tile_x_in),
    .tile_y_in     (tile_y_in),
    .tile_ready    (tile_ready),
    .map_addr      (map_addr),
    .map_data      (map_data),
    .x_out         (x_out),
    .y_out         (y_out),
    .sprite_id_out (sprite_id_out),
    .draw_start    (draw_start),
    .draw_done     (draw_done),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) map_data <= map_mem[map_addr];

  // Monitor: records every issued draw and counts frame_done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (draw_start === 1'b1) begin
        obs_x.push_back(x_out);
        obs_y.push_back(y_out);
        obs_id.push_back(sprite_id_out);
        start_cnt++;
      end
      if (frame_done === 1'b1) frame_cnt++;
    end
  end

  // sprite_draw stand-in: answers each start after resp_delay cycles and
  // flags any change of the draw arguments while the sprite is in flight.
  initial begin
    forever begin
      @(negedge clk);
      if (inject_req != inject_ack) begin
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        inject_ack++;
      end else if (resp_en && draw_start === 1'b1) begin
        rs_x = x_out; rs_y = y_out; rs_id = sprite_id_out;
        for (int k = 0; k < resp_delay; k++) begin
          @(negedge clk);
          if (x_out !== rs_x || y_out !== rs_y || sprite_id_out !== rs_id) stab_err++;
        end
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, tests_run=%0d required=finish", tests_run);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] px_x(input int tx);
    return 8'(16 + tx * 8);
  endfunction

  function automatic logic [6:0] px_y(input int ty);
    return 7'(12 + ty * 8);
  endfunction

  task automatic do_reset();
    resp_en = 1'b0;
    full_req = 1'b0;
    tile_req = 1'b0;
    tile_x_in = '0;
    tile_y_in = '0;
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Idle means busy low for several consecutive cycles (it dips for one
  // cycle between queued single draws).
  task automatic wait_idle(input int max_cycles, output bit ok);
    int quiet;
    ok = 1'b0;
    quiet = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(negedge clk);
      quiet = (busy === 1'b0) ? quiet + 1 : 0;
      if (quiet >= 4) ok = 1'b1;
    end
  endtask

  task automatic wait_frames(input int target, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(negedge clk);
      if (frame_cnt >= target && busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (busy !== 1'b0 || draw_start !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b start=%b frame_done=%b required 0 0 0", busy, draw_start, frame_done);
    end
    tests_run++;
    if (tile_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_tile_ready: got %b required 1", tile_ready);
    end
    tests_run++;
    if (x_out !== 8'd0 || y_out !== 7'd0 || sprite_id_out !== 3'd0 || map_addr !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_data: x=%0d y=%0d id=%0d addr=%0d required all 0", x_out, y_out, sprite_id_out, map_addr);
    end
  endtask

  task automatic test_full_latency();
    int lat, hi_start, lo_busy;
    bit found;
    do_reset();
    @(negedge clk);
    full_req = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      full_req = 1'b0;
      if (draw_start === 1'b1) begin
        found = 1'b1;
        lat = i;
      end
    end
    tests_run++;
    if (lat != 4) begin
      tests_failed++;
      $display("FAIL full_latency: draw_start after %0d cycles required 4", lat);
    end
    tests_run++;
    if (map_addr !== 8'd0 || x_out !== 8'd16 || y_out !== 7'd12 || sprite_id_out !== map_mem[0]) begin
      tests_failed++;
      $display("FAIL first_tile: addr=%0d x=%0d y=%0d id=%0d required 0 16 12 %0d",
               map_addr, x_out, y_out, sprite_id_out, map_mem[0]);
    end
    hi_start = 0;
    lo_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (draw_start === 1'b1) hi_start++;
      if (busy !== 1'b1) lo_busy++;
    end
    tests_run++;
    if (hi_start != 0 || lo_busy != 0) begin
      tests_failed++;
      $display("FAIL stuck_wait: extra starts=%0d busy-low cycles=%0d required 0 0", hi_start, lo_busy);
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    int ob, fb, sb, n;
    do_reset();
    resp_delay = 10;
    resp_en = 1'b1;
    ob = obs_x.size();
    fb = frame_cnt;
    sb = stab_err;
    @(negedge clk); full_req = 1'b1;
    @(negedge clk); full_req = 1'b0;
    wait_frames(fb + 1, 10000, ok);
    repeat (5) @(negedge clk);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL full_frame_timeout: frames=%0d required 1", frame_cnt - fb);
    end
    n = obs_x.size() - ob;
    tests_run++;
    if (n != 192) begin
      tests_failed++;
      $display("FAIL full_frame_count: draws=%0d required 192", n);
    end
    for (int k = 0; k < n && k < 192; k++) begin
      tests_run++;
      if (obs_x[ob+k] !== px_x(k % 16) || obs_y[ob+k] !== px_y(k / 16) || obs_id[ob+k] !== map_mem[k]) begin
        tests_failed++;
        $display("FAIL full_frame_tile%0d: x=%0d y=%0d id=%0d required %0d %0d %0d", k,
                 obs_x[ob+k], obs_y[ob+k], obs_id[ob+k], px_x(k % 16), px_y(k / 16), map_mem[k]);
      end
    end
    if (n > 0) begin
      tests_run++;
      if (obs_x[ob+n-1] !== 8'd136 || obs_y[ob+n-1] !== 7'd100) begin
        tests_failed++;
        $display("FAIL full_frame_last: x=%0d y=%0d required 136 100", obs_x[ob+n-1], obs_y[ob+n-1]);
      end
    end
    tests_run++;
    if (frame_cnt - fb != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_done_once: pulses=%0d busy=%b required 1 0", frame_cnt - fb, busy);
    end
    tests_run++;
    if (stab_err != sb) begin
      tests_failed++;
      $display("FAIL draw_args_stable: changes=%0d required 0", stab_err - sb);
    end
  endtask

  task automatic test_single_tile();
    bit ok;
    int ob, sb;
    do_reset();
    map_mem[37] = 3'd5;
    resp_delay = 5;
    resp_en = 1'b1;
    ob = obs_x.size();
    sb = start_cnt;
    @(negedge clk); tile_x_in = 4'd5; tile_y_in = 4'd2; tile_req = 1'b1;
    @(negedge clk); tile_req = 1'b0;
    wait_idle(200, ok);
    tests_run++;
    if (!ok || start_cnt - sb != 1) begin
      tests_failed++;
      $display("FAIL single_count: idle=%0b starts=%0d required 1 1", ok, start_cnt - sb);
    end
    if (obs_x.size() > ob) begin
      tests_run++;
      if (obs_id[ob] !== 3'd5 || obs_x[ob] !== 8'd56 || obs_y[ob] !== 7'd28) begin
        tests_failed++;
        $display("FAIL single_tile: id=%0d x=%0d y=%0d required 5 56 28", obs_id[ob], obs_x[ob], obs_y[ob]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int ob, sb, n, nreq, qcnt;
    logic [3:0] rx, ry;
    logic [7:0] ex [$];
    logic [6:0] ey [$];
    logic [2:0] eid [$];
    do_reset();
    resp_delay = 30;
    resp_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      ex.delete(); ey.delete(); eid.delete();
      ob = obs_x.size();
      sb = start_cnt;
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 11));
      ex.push_back(px_x(int'(rx))); ey.push_back(px_y(int'(ry))); eid.push_back(map_mem[ry*16 + rx]);
      @(negedge clk); tile_x_in = rx; tile_y_in = ry; tile_req = 1'b1;
      @(negedge clk); tile_req = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (start_cnt > sb) ok = 1'b1;
      end
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL b2b_primer_r%0d: no draw_start, required 1", r);
      end
      nreq = (r == 0) ? 5 : $urandom_range(3, 7);
      qcnt = 0;
      for (int j = 0; j < nreq; j++) begin
        rx = 4'($urandom_range(0, 15));
        ry = (r == 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 15));
        tests_run++;
        if (tile_ready !== (qcnt < 4)) begin
          tests_failed++;
          $display("FAIL b2b_tile_ready_r%0d_req%0d: got %b required %b", r, j, tile_ready, (qcnt < 4));
        end
        tile_x_in = rx; tile_y_in = ry; tile_req = 1'b1;
        if (ry < 12 && qcnt < 4) begin
          ex.push_back(px_x(int'(rx))); ey.push_back(px_y(int'(ry))); eid.push_back(map_mem[ry*16 + rx]);
          qcnt++;
        end
        @(negedge clk);
      end
      tile_req = 1'b0;
      wait_idle(3000, ok);
      n = obs_x.size() - ob;
      tests_run++;
      if (!ok || n != ex.size()) begin
        tests_failed++;
        $display("FAIL b2b_count_r%0d: idle=%0b draws=%0d required 1 %0d", r, ok, n, ex.size());
      end
      for (int k = 0; k < n && k < ex.size(); k++) begin
        tests_run++;
        if (obs_x[ob+k] !== ex[k] || obs_y[ob+k] !== ey[k] || obs_id[ob+k] !== eid[k]) begin
          tests_failed++;
          $display("FAIL b2b_draw_r%0d_%0d: x=%0d y=%0d id=%0d required %0d %0d %0d", r, k,
                   obs_x[ob+k], obs_y[ob+k], obs_id[ob+k], ex[k], ey[k], eid[k]);
        end
      end
    end
  endtask

  task automatic test_full_during_frame();
    bit ok;
    int ob, fb, sb, n, found;
    do_reset();
    resp_delay = 2;
    resp_en = 1'b1;
    ob = obs_x.size();
    fb = frame_cnt;
    @(negedge clk); full_req = 1'b1;
    @(negedge clk); full_req = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (obs_x.size() - ob >= 50) found = 1;
    end
    full_req = 1'b1; tile_x_in = 4'd3; tile_y_in = 4'd3; tile_req = 1'b1;
    @(negedge clk); full_req = 1'b0; tile_x_in = 4'd4; tile_y_in = 4'd4;
    @(negedge clk); tile_req = 1'b0;
    wait_frames(fb + 2, 20000, ok);
    sb = start_cnt;
    repeat (20) @(negedge clk);
    n = obs_x.size() - ob;
    tests_run++;
    if (!ok || frame_cnt - fb != 2) begin
      tests_failed++;
      $display("FAIL refresh_frames: done=%0b frames=%0d required 1 2", ok, frame_cnt - fb);
    end
    tests_run++;
    if (n != 384 || start_cnt != sb) begin
      tests_failed++;
      $display("FAIL refresh_count: draws=%0d late starts=%0d required 384 0", n, start_cnt - sb);
    end
    for (int k = 0; k < n && k < 384; k++) begin
      tests_run++;
      if (obs_x[ob+k] !== px_x((k % 192) % 16) || obs_y[ob+k] !== px_y((k % 192) / 16) ||
          obs_id[ob+k] !== map_mem[k % 192]) begin
        tests_failed++;
        $display("FAIL refresh_tile%0d: x=%0d y=%0d id=%0d required %0d %0d %0d", k,
                 obs_x[ob+k], obs_y[ob+k], obs_id[ob+k],
                 px_x((k % 192) % 16), px_y((k % 192) / 16), map_mem[k % 192]);
      end
    end
  endtask

  task automatic test_full_tile_same_cycle();
    bit ok;
    int ob, fb, sb, n;
    do_reset();
    resp_delay = 1;
    resp_en = 1'b1;
    ob = obs_x.size();
    fb = frame_cnt;
    @(negedge clk); full_req = 1'b1; tile_req = 1'b1; tile_x_in = 4'd7; tile_y_in = 4'd7;
    @(negedge clk); full_req = 1'b0; tile_req = 1'b0;
    wait_frames(fb + 1, 10000, ok);
    sb = start_cnt;
    repeat (20) @(negedge clk);
    n = obs_x.size() - ob;
    tests_run++;
    if (!ok || n != 192 || start_cnt != sb) begin
      tests_failed++;
      $display("FAIL same_cycle_flush: done=%0b draws=%0d late=%0d required 1 192 0", ok, n, start_cnt - sb);
    end
    if (n > 0) begin
      tests_run++;
      if (obs_x[ob] !== 8'd16 || obs_y[ob] !== 7'd12) begin
        tests_failed++;
        $display("FAIL same_cycle_first: x=%0d y=%0d required 16 12", obs_x[ob], obs_y[ob]);
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    bit ok;
    int sb, hi;
    do_reset();
    sb = start_cnt;
    @(negedge clk); tile_x_in = 4'd2; tile_y_in = 4'd3; tile_req = 1'b1;
    @(negedge clk); tile_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (start_cnt > sb) ok = 1'b1;
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (!ok || busy !== 1'b1 || x_out !== 8'd32) begin
      tests_failed++;
      $display("FAIL mid_draw_setup: started=%0b busy=%b x=%0d required 1 1 32", ok, busy, x_out);
    end
    resetn = 1'b0;
    #1;
    tests_run++;
    if (draw_start !== 1'b0 || busy !== 1'b0 || tile_ready !== 1'b1 || x_out !== 8'd0 || y_out !== 7'd0) begin
      tests_failed++;
      $display("FAIL async_reset: start=%b busy=%b ready=%b x=%0d y=%0d required 0 0 1 0 0",
               draw_start, busy, tile_ready, x_out, y_out);
    end
    @(negedge clk); resetn = 1'b1;
    inject_req++;
    hi = 0;
    sb = start_cnt;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || frame_done !== 1'b0) hi++;
    end
    tests_run++;
    if (hi != 0 || start_cnt != sb || inject_ack != inject_req) begin
      tests_failed++;
      $display("FAIL stray_done: active cycles=%0d starts=%0d injected=%0d required 0 0 1",
               hi, start_cnt - sb, inject_ack - inject_req + 1);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) map_mem[a] = 3'($urandom_range(0, 7));
    test_reset();
    test_full_latency();
    test_full_frame();
    test_single_tile();
    test_back_to_back();
    test_full_during_frame();
    test_full_tile_same_cycle();
    test_reset_mid_draw();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/board_render_seq.md
Name: board_render_seq

Overview:
Upstream sequencer for sprite_draw. It walks the Sokoban level map and issues one sprite draw per tile, either as a full-board redraw or as queued single-tile redraws after a move. For each tile it reads the tile code from map RAM and converts tile coordinates to pixel coordinates. It then drives x/y/sprite_id plus a start strobe into sprite_draw and waits for its done pulse before moving to the next tile.

Parameters:
GRID_W, 16, tiles per row (max 16)
GRID_H, 12, tiles per column (max 16)
TILE_PX, 8, sprite edge in pixels (power of 2)
ORIGIN_X, 16, pixel x of tile (0,0)
ORIGIN_Y, 12, pixel y of tile (0,0)
QDEPTH, 4, single-tile request FIFO depth

Ports:
clk  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset
full_req  in  1  one-cycle pulse: redraw entire board
tile_req  in  1  one-cycle pulse: redraw tile (tile_x_in, tile_y_in)
tile_x_in  in  4  tile column for tile_req
tile_y_in  in  4  tile row for tile_req
tile_ready  out  1  FIFO not full; tile_req is accepted only when high
map_addr  out  8  map RAM read address = ty*GRID_W + tx
map_data  in  3  tile code, valid 1 cycle after map_addr
x_out  out  8  pixel x to sprite_draw.x_in
y_out  out  7  pixel y to sprite_draw.y_in
sprite_id_out  out  3  sprite code to sprite_draw.sprite_id_in
draw_start  out  1  one-cycle active-high start pulse to sprite_draw
draw_done  in  1  one-cycle pulse from sprite_draw when the sprite is finished
busy  out  1  high whenever not in IDLE
frame_done  out  1  one-cycle pulse at the end of a full redraw

Behaviour:
- Reset (async, resetn=0): state IDLE; FIFO empty; full_pending=0; all outputs 0, except tile_ready=1.
- Tile codes pass straight through as sprite_id: 0 floor, 1 wall, 2 box, 3 goal, 4 box-on-goal, 5 player, 6 player-on-goal, 7 blank.
- Pixel coordinates: x_out = ORIGIN_X + tx*TILE_PX (8-bit); y_out = ORIGIN_Y + ty*TILE_PX (7-bit). Multiplication is a shift. Parameters must keep the board on a 160x120 screen; no overflow check is performed.
- FSM states: IDLE, FETCH, READ, ISSUE, WAIT_DONE, ADVANCE.
- IDLE:
  - If full_pending: clear it, flush the FIFO, mode=FULL, tx=ty=0, go to FETCH.
  - Else if the FIFO is non-empty: pop it, mode=SINGLE, go to FETCH.
- FETCH: drive map_addr and go to READ. READ: capture map_data into sprite_id_out and register x_out/y_out.
- ISSUE: draw_start=1 for exactly one cycle; x_out, y_out and sprite_id_out stay stable from ISSUE until draw_done.
- WAIT_DONE: wait for draw_done, then go to ADVANCE. draw_done in any other state is ignored.
- ADVANCE:
  - SINGLE: go to IDLE.
  - FULL: step tx row-major, wrapping tx at GRID_W-1 and incrementing ty.
  - After tile (GRID_W-1, GRID_H-1): pulse frame_done and go to IDLE, or restart at (0,0) if full_pending is set.
- Latency: full_req in IDLE → draw_start 4 cycles later (IDLE, FETCH, READ, ISSUE).
- full_req arriving during a full redraw sets full_pending. The current sprite completes; the scan restarts at (0,0) only after the current frame ends (no mid-frame abort).
- tile_req while the FIFO is full is dropped; tile_ready must be sampled by the requester.
- tile_req and a pop in the same cycle are both honoured.
- full_req and tile_req in the same cycle: both are latched; the later flush discards the tile request.
- Out-of-range tile_x_in/tile_y_in (≥ GRID_W/GRID_H) is discarded at enqueue.
- busy = (state != IDLE).
- Reset mid-draw abandons the sprite; sprite_draw shares resetn.

Decomposition:
- Shared package sokoban_pkg:
  - Tile-code constants (TILE_FLOOR … TILE_BLANK)
  - Screen limits (160x120)
  - Default GRID_W/GRID_H/TILE_PX/ORIGIN
- Sub-module: tile_req_fifo (QDEPTH x 8-bit synchronous FIFO with full/empty, push, pop, flush).

Test Plan:
- Reset with draw_done stuck at 0, then full_req: draw_start appears 4 cycles after full_req with map_addr=0, x_out=16, y_out=12. busy stays high.
- Full redraw on a 16x12 map with draw_done 10 cycles after each start: exactly 192 draw_start pulses. The last has x_out=136, y_out=100. One frame_done pulse follows, then IDLE.
- Map RAM with code 5 at addr 37: tile_req (5,2) gives sprite_id_out=5, x_out=56, y_out=28, one draw_start, then busy drops after draw_done.
- Five tile_req pulses back-to-back while busy: tile_ready goes low after 4, the fifth is dropped, and exactly 4 single draws follow.
- full_req during tile 50 of a frame: the frame completes (frame_done), then a second full scan starts at (0,0). Queued tile requests are flushed.
- Assert resetn=0 in WAIT_DONE: outputs clear immediately (draw_start=0, busy=0, tile_ready=1). After release, a stray draw_done is ignored.
